turbosound_mixer: RTL



---
 rtl/turbosound_mix_pkg.sv | 56 +++++
 rtl/mix_sdm.sv | 26 ++
 rtl/turbosound_mixer.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/turbosound_mix_pkg.sv
// Shared constants for the TurboSound stereo mixer: stereo modes,
// per-mode channel weights, FSM encodings and accumulator width.
package turbosound_mix_pkg;

  localparam int ACC_W = 11;

  localparam logic [1:0] MODE_MONO = 2'd0;
  localparam logic [1:0] MODE_ABC  = 2'd1;
  localparam logic [1:0] MODE_ACB  = 2'd2;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ACC  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef struct packed {
    logic [1:0] wl;
    logic [1:0] wr;
  } weight_t;

  // idx is the channel within one AY: 0 = A, 1 = B, 2 = C
  function automatic weight_t chan_weight(
    input logic [1:0] mode,
    input logic [1:0] idx
  );
    weight_t w;
    w = '{wl: 2'd1, wr: 2'd1};
    if (mode == MODE_ABC) begin
      case (idx)
        2'd0:    w = '{wl: 2'd2, wr: 2'd0};
        2'd2:    w = '{wl: 2'd0, wr: 2'd2};
        default: w = '{wl: 2'd1, wr: 2'd1};
      endcase
    end else if (mode == MODE_ACB) begin
      case (idx)
        2'd0:    w = '{wl: 2'd2, wr: 2'd0};
        2'd1:    w = '{wl: 2'd0, wr: 2'd2};
        default: w = '{wl: 2'd1, wr: 2'd1};
      endcase
    end
    return w;
  endfunction

  function automatic logic [ACC_W-1:0] scale(
    input logic [1:0] w,
    input logic [7:0] x
  );
    logic [ACC_W-1:0] r;
    case (w)
      2'd2:    r = ACC_W'({x, 1'b0});
      2'd1:    r = ACC_W'(x);
      default: r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mix_sdm.sv
// Single-channel first-order sigma-delta modulator; the output bit is
// the carry of an OUT_W+1 bit error accumulator.
module mix_sdm #(
  parameter int W = 12
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] x,
  output logic         y
);

  logic [W:0] err_q;
  logic [W:0] err_d;

  always_comb begin
    err_d = {1'b0, err_q[W-1:0]} + {1'b0, x};
  end

  always_ff @(posedge clk) begin
    if (rst) err_q <= '0;
    else     err_q <= err_d;
  end

  assign y = err_q[W];

endmodule

// File: rtl/turbosound_mixer.sv
// Time-multiplexed TurboSound stereo mixer, one AY channel per clock.
// Define TURBOSOUND_MIX_SDM_EN to add 1-bit sigma-delta outputs.
module turbosound_mixer
  import turbosound_mix_pkg::*;
#(
  parameter int OUT_W   = 12,
  parameter int EAR_LVL = 192,
  parameter int MIC_LVL = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sample_start,
  input  logic [1:0]       stereo_mode,
  input  logic             disable_turboay,
  input  logic [23:0]      ay1_abc,
  input  logic [23:0]      ay2_abc,
  input  logic             ear,
  input  logic             mic,
  output logic [OUT_W-1:0] left,
  output logic [OUT_W-1:0] right,
  output logic             sample_valid,
  output logic             overrun,
  output logic             sdm_l,
  output logic             sdm_r
);

  logic [1:0]       state_q, state_d;
  logic [2:0]       ch_q, ch_d;
  logic [ACC_W-1:0] acc_l_q, acc_l_d;
  logic [ACC_W-1:0] acc_r_q, acc_r_d;
  logic [5:0][7:0]  snap_q, snap_d;
  logic [1:0]       mode_q, mode_d;
  logic [OUT_W-1:0] left_q, left_d;
  logic [OUT_W-1:0] right_q, right_d;
  logic             valid_q, valid_d;
  logic             overrun_q, overrun_d;

  logic [2:0]       ch_m3;
  logic [1:0]       idx;
  logic [7:0]       cur;
  weight_t          w;
  logic [ACC_W-1:0] sum_l, sum_r;
  logic [ACC_W-1:0] preload;

  // ch 0..2 walk AY1 A,B,C; ch 3..5 walk AY2 A,B,C
  always_comb begin
    ch_m3 = ch_q - 3'd3;
    idx   = (ch_q >= 3'd3) ? ch_m3[1:0] : ch_q[1:0];
    cur   = snap_q[ch_q];
    w     = chan_weight(mode_q, idx);
    sum_l = acc_l_q + scale(w.wl, cur);
    sum_r = acc_r_q + scale(w.wr, cur);
    preload = (ear ? ACC_W'(EAR_LVL) : '0)
            + (mic ? ACC_W'(MIC_LVL) : '0);
  end

  always_comb begin
    state_d   = state_q;
    ch_d      = ch_q;
    acc_l_d   = acc_l_q;
    acc_r_d   = acc_r_q;
    snap_d    = snap_q;
    mode_d    = mode_q;
    left_d    = left_q;
    right_d   = right_q;
    valid_d   = 1'b0;
    overrun_d = overrun_q;
    unique case (state_q)
      ST_IDLE: begin
        if (sample_start) begin
          snap_d[0] = ay1_abc[23:16];
          snap_d[1] = ay1_abc[15:8];
          snap_d[2] = ay1_abc[7:0];
          snap_d[3] = disable_turboay ? 8'd0 : ay2_abc[23:16];
          snap_d[4] = disable_turboay ? 8'd0 : ay2_abc[15:8];
          snap_d[5] = disable_turboay ? 8'd0 : ay2_abc[7:0];
          mode_d    = stereo_mode;
          acc_l_d   = preload;
          acc_r_d   = preload;
          ch_d      = 3'd0;
          state_d   = ST_ACC;
        end
      end
      ST_ACC: begin
        overrun_d = overrun_q | sample_start;
        acc_l_d   = sum_l;
        acc_r_d   = sum_r;
        // Last channel loads the outputs so valid lands in the DONE cycle
        if (ch_q == 3'd5) begin
          left_d  = OUT_W'(sum_l);
          right_d = OUT_W'(sum_r);
          valid_d = 1'b1;
          state_d = ST_DONE;
        end else begin
          ch_d = ch_q + 3'd1;
        end
      end
      ST_DONE: begin
        overrun_d = overrun_q | sample_start;
        state_d   = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      ch_q      <= '0;
      acc_l_q   <= '0;
      acc_r_q   <= '0;
      snap_q    <= '0;
      mode_q    <= MODE_MONO;
      left_q    <= '0;
      right_q   <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ch_q      <= ch_d;
      acc_l_q   <= acc_l_d;
      acc_r_q   <= acc_r_d;
      snap_q    <= snap_d;
      mode_q    <= mode_d;
      left_q    <= left_d;
      right_q   <= right_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
    end
  end

  assign left         = left_q;
  assign right        = right_q;
  assign sample_valid = valid_q;
  assign overrun      = overrun_q;

`ifdef TURBOSOUND_MIX_SDM_EN
  mix_sdm #(.W(OUT_W)) u_sdm_l (
    .clk (clk),
    .rst (rst),
    .x   (left_q),
    .y   (sdm_l)
  );

  mix_sdm #(.W(OUT_W)) u_sdm_r (
    .clk (clk),
    .rst (rst),
    .x   (right_q),
    .y   (sdm_r)
  );
`else
  assign sdm_l = 1'b0;
  assign sdm_r = 1'b0;
`endif

endmodule
